// File: rtl/p_to_s.sv
// Parallel-to-serial word transmitter, LSB first; first bit appears the cycle after accept.
// One-word holding register hides word boundaries; ready_b low freezes data_b/last_b and ready_a drops once H is full.
module p_to_s #(
  parameter int DW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_a,
  input  logic [DW-1:0] data_a,
  output logic          ready_a,
  output logic          valid_b,
  output logic          data_b,
  output logic          last_b,
  input  logic          ready_b
);

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] s_q, s_d;
  logic [DW-1:0] h_q, h_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hf_q, hf_d;
  logic          ready_a_q;

  logic busy, at_last, accept, xfer, last_xfer, load_slot;

  assign busy      = (state_q == SHIFT);
  assign at_last   = (cnt_q == CNT_LAST);
  assign accept    = valid_a && ready_a_q;
  assign xfer      = busy && ready_b;
  assign last_xfer = xfer && at_last;
  // The shift slot opens when idle or as the final bit of the current word leaves.
  assign load_slot = !busy || last_xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (load_slot) begin
      state_d = (hf_q || accept) ? SHIFT : IDLE;
    end
  end

  always_comb begin
    valid_b = busy;
    data_b  = s_q[0];
    last_b  = busy && at_last;
    ready_a = ready_a_q;
  end

  // A held word always wins the slot; ready_a is low whenever hf is set, so no accept collides with it.
  always_comb begin
    s_d   = s_q;
    h_d   = h_q;
    cnt_d = cnt_q;
    hf_d  = hf_q;
    if (load_slot) begin
      if (hf_q) begin
        s_d   = h_q;
        cnt_d = '0;
        hf_d  = 1'b0;
      end else if (accept) begin
        s_d   = data_a;
        cnt_d = '0;
      end
    end else begin
      if (accept) begin
        h_d  = data_a;
        hf_d = 1'b1;
      end
      if (xfer) begin
        s_d   = s_q >> 1;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q       <= '0;
      h_q       <= '0;
      cnt_q     <= '0;
      hf_q      <= 1'b0;
      ready_a_q <= 1'b0;
    end else begin
      s_q       <= s_d;
      h_q       <= h_d;
      cnt_q     <= cnt_d;
      hf_q      <= hf_d;
      ready_a_q <= !hf_d;
    end
  end

endmodule

// File: tb/tb_p_to_s.sv
// Directed bench for p_to_s: DW=6 instance for handshake/backpressure/reset cases, DW=8 instance for width.
module tb_p_to_s;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_a, ready_a, valid_b, data_b, last_b, ready_b;
  logic [5:0] data_a;
  logic       v8_a, r8_a, v8_b, d8_b, l8_b, r8_b;
  logic [7:0] d8_a;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  p_to_s #(.DW(6)) u6 (
    .clk(clk), .rst_n(rst_n),
    .valid_a(valid_a), .data_a(data_a), .ready_a(ready_a),
    .valid_b(valid_b), .data_b(data_b), .last_b(last_b), .ready_b(ready_b)
  );

  p_to_s #(.DW(8)) u8 (
    .clk(clk), .rst_n(rst_n),
    .valid_a(v8_a), .data_a(d8_a), .ready_a(r8_a),
    .valid_b(v8_b), .data_b(d8_b), .last_b(l8_b), .ready_b(r8_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    logic [5:0]  w;
    logic [5:0]  words [3];
    logic [17:0] exp_bits;
    logic [17:0] exp_rdy;
    logic [8:0]  pat;
    logic [11:0] hold_bits;
    logic [7:0]  w8;
    int          idx, bi;
    logic        acc;

    rst_n = 1'b0; valid_a = 1'b0; data_a = '0; ready_b = 1'b0;
    v8_a = 1'b0; d8_a = '0; r8_b = 1'b0;
    cyc(); cyc();

    // Reset state
    check("rst_ready_a", ready_a, 0);
    check("rst_valid_b", valid_b, 0);
    check("rst_data_b",  data_b,  0);
    check("rst_last_b",  last_b,  0);
    check("rst8_ready_a", r8_a, 0);
    check("rst8_valid_b", v8_b, 0);

    rst_n = 1'b1;
    cyc();
    check("rel_ready_a", ready_a, 1);
    check("rel_valid_b", valid_b, 0);

    // Single word 6'b101100
    w = 6'b101100;
    ready_b = 1'b1; valid_a = 1'b1; data_a = w;
    cyc();
    valid_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("single_vld_%0d", i),  valid_b, 1);
      check($sformatf("single_bit_%0d", i),  data_b, w[i]);
      check($sformatf("single_last_%0d", i), last_b, (i == 5) ? 1 : 0);
      cyc();
    end
    check("single_end_vld", valid_b, 0);
    check("single_end_rdy", ready_a, 1);

    // Back-to-back 2A, 15, 3F
    words[0] = 6'h2A; words[1] = 6'h15; words[2] = 6'h3F;
    exp_bits = {6'h3F, 6'h15, 6'h2A};
    exp_rdy  = 18'b111111_000001_000001;
    idx = 0;
    valid_a = 1'b1; data_a = words[0];
    for (int i = 0; i < 18; i++) begin
      acc = valid_a && ready_a;
      cyc();
      if (acc) begin
        idx++;
        if (idx == 3) valid_a = 1'b0;
        else data_a = words[idx];
      end
      check($sformatf("b2b_vld_%0d", i),  valid_b, 1);
      check($sformatf("b2b_bit_%0d", i),  data_b, exp_bits[i]);
      check($sformatf("b2b_last_%0d", i), last_b, (i % 6 == 5) ? 1 : 0);
      check($sformatf("b2b_rdy_%0d", i),  ready_a, exp_rdy[i]);
    end
    valid_a = 1'b0;
    check("b2b_accepted", idx, 3);
    cyc();
    check("b2b_end_vld", valid_b, 0);

    // Backpressure on word 6'b000111
    w = 6'b000111;
    pat = 9'b111011001;
    ready_b = 1'b0; valid_a = 1'b1; data_a = w;
    cyc();
    valid_a = 1'b0;
    bi = 0;
    for (int j = 0; j < 9; j++) begin
      ready_b = pat[j];
      check($sformatf("bp_vld_%0d", j),  valid_b, 1);
      check($sformatf("bp_bit_%0d", j),  data_b, w[bi]);
      check($sformatf("bp_last_%0d", j), last_b, (bi == 5) ? 1 : 0);
      cyc();
      if (pat[j]) bi++;
    end
    check("bp_end_vld", valid_b, 0);

    // Holding register full under ready_b = 0
    ready_b = 1'b0; valid_a = 1'b1; data_a = 6'h01;
    cyc();
    check("hf_rdy_after_1", ready_a, 1);
    data_a = 6'h02;
    cyc();
    data_a = 6'h03;
    for (int j = 0; j < 3; j++) begin
      check($sformatf("hf_rdy_low_%0d", j), ready_a, 0);
      check($sformatf("hf_hold_bit_%0d", j), data_b, 1);
      check($sformatf("hf_hold_last_%0d", j), last_b, 0);
      cyc();
    end
    valid_a = 1'b0; ready_b = 1'b1;
    hold_bits = {6'h02, 6'h01};
    for (int i = 0; i < 12; i++) begin
      check($sformatf("hf_vld_%0d", i), valid_b, 1);
      check($sformatf("hf_bit_%0d", i), data_b, hold_bits[i]);
      cyc();
    end
    check("hf_end_vld", valid_b, 0);

    // Reset after 3 bits of 3F with a word held
    valid_a = 1'b1; data_a = 6'h3F;
    cyc();
    data_a = 6'h2A;
    cyc();
    valid_a = 1'b0;
    check("mid_hf_rdy", ready_a, 0);
    cyc(); cyc();
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready_a", ready_a, 0);
    check("mid_rst_valid_b", valid_b, 0);
    check("mid_rst_data_b",  data_b,  0);
    check("mid_rst_last_b",  last_b,  0);
    cyc(); cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      check($sformatf("post_rst_vld_%0d", i), valid_b, 0);
    end
    check("post_rst_rdy", ready_a, 1);
    w = 6'h15;
    valid_a = 1'b1; data_a = w;
    cyc();
    valid_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("post_rst_bit_%0d", i), data_b, w[i]);
      cyc();
    end
    check("post_rst_end_vld", valid_b, 0);

    // DW = 8 instance
    w8 = 8'hA5;
    check("dw8_rdy", r8_a, 1);
    r8_b = 1'b1; v8_a = 1'b1; d8_a = w8;
    cyc();
    v8_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("dw8_vld_%0d", i),  v8_b, 1);
      check($sformatf("dw8_bit_%0d", i),  d8_b, w8[i]);
      check($sformatf("dw8_last_%0d", i), l8_b, (i == 7) ? 1 : 0);
      cyc();
    end
    check("dw8_end_vld", v8_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
